// File: rtl/sie_pkg.sv
// Shared types and constants for the SIE transmit path.
package sie_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PID,
    PAYLOAD,
    CRC
  } sie_tx_state_t;

  typedef enum logic [1:0] {
    TOKEN,
    DATA,
    HS
  } sie_pkt_t;

  localparam int unsigned SIE_PID_BITS   = 8;
  localparam int unsigned SIE_CRC5_BITS  = 5;
  localparam int unsigned SIE_CRC16_BITS = 16;

  // PID byte as sent on the wire: pid[3:0] then its complement, LSB first.
  function automatic logic [7:0] sie_pid_frame(input logic [3:0] p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/sie_phase_cnt.sv
// Loadable down-counter for phase bit counts; 'last' flags the final bit.
// Decrements only while non-zero, so it never wraps.
module sie_phase_cnt #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load takes priority over a decrement in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/sie_tx_mux.sv
// Transmit packet sequencer: PID -> payload -> CRC with bit handshake.
// Build option: define SIE_TX_MUX_HS_EN to support handshake (PID-only) packets.
module sie_tx_mux
  import sie_pkg::*;
#(
  parameter int unsigned TOKEN_BITS = 11,
  parameter int unsigned MAX_BYTES  = 64,
  parameter int unsigned LEN_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             token_pkt,
  input  logic             data_pkt,
  input  logic             hs_pkt,
  input  logic [3:0]       pid,
  input  logic [LEN_W-1:0] data_len,
  input  logic             stream5,
  input  logic             stream16,
  input  logic             crc5,
  input  logic             crc16,
  input  logic             bit_en,
  output logic             out_to_stuff,
  output logic             out_valid,
  output logic             stream_adv,
  output logic             crc_adv,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES * 8 + 1);

  sie_tx_state_t    state_q, state_d;
  sie_pkt_t         type_q, type_d;
  logic [7:0]       pid_sr_q, pid_sr_d;
  logic [CNT_W-1:0] pay_bits_q, pay_bits_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_last;
  logic             consume;

  logic             hs_req;
  logic             any_start;
  logic             multi_start;
  logic             len_clamp;
  logic [LEN_W-1:0] len_eff;
  logic [CNT_W-1:0] len_bits;

`ifdef SIE_TX_MUX_HS_EN
  assign hs_req = hs_pkt;
`else
  logic hs_unused;
  assign hs_unused = hs_pkt;
  assign hs_req    = 1'b0;
`endif

  assign any_start   = token_pkt | data_pkt | hs_req;
  assign multi_start = (token_pkt & (data_pkt | hs_req)) | (data_pkt & hs_req);
  assign len_clamp   = (data_len > LEN_W'(MAX_BYTES));
  assign len_eff     = len_clamp ? LEN_W'(MAX_BYTES) : data_len;
  assign len_bits    = CNT_W'({len_eff, 3'b000});

  assign out_valid = (state_q != IDLE);
  assign consume   = out_valid & bit_en;

  sie_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (consume),
    .last     (cnt_last)
  );

  // Serial bit select and source advance strobes for the current phase.
  always_comb begin
    out_to_stuff = 1'b0;
    stream_adv   = 1'b0;
    crc_adv      = 1'b0;
    case (state_q)
      IDLE:    ;
      PID:     out_to_stuff = pid_sr_q[0];
      PAYLOAD: begin
        out_to_stuff = (type_q == TOKEN) ? stream5 : stream16;
        stream_adv   = bit_en;
      end
      CRC:     begin
        out_to_stuff = (type_q == TOKEN) ? crc5 : crc16;
        crc_adv      = bit_en;
      end
    endcase
  end

  // Sequencer next-state, phase counter loads and registered status pulses.
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    pid_sr_d   = pid_sr_q;
    pay_bits_d = pay_bits_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    case (state_q)
      IDLE: begin
        if (any_start) begin
          state_d  = PID;
          pid_sr_d = sie_pid_frame(pid);
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SIE_PID_BITS);
          err_d    = multi_start | (!token_pkt & data_pkt & len_clamp);
          if (token_pkt) begin
            type_d = TOKEN;
          end else if (data_pkt) begin
            type_d     = DATA;
            pay_bits_d = len_bits;
          end else begin
            type_d = HS;
          end
        end
      end
      PID: begin
        err_d = any_start;
        if (bit_en) begin
          pid_sr_d = {1'b0, pid_sr_q[7:1]};
          if (cnt_last) begin
            if (type_q == TOKEN) begin
              state_d  = PAYLOAD;
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(TOKEN_BITS);
            end
`ifdef SIE_TX_MUX_HS_EN
            else if (type_q == HS) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
`endif
            else if (pay_bits_q == '0) begin
              state_d  = CRC;
              cnt_load = 1'b1;
              cnt_val  = CNT_W'(SIE_CRC16_BITS);
            end else begin
              state_d  = PAYLOAD;
              cnt_load = 1'b1;
              cnt_val  = pay_bits_q;
            end
          end
        end
      end
      PAYLOAD: begin
        err_d = any_start;
        if (bit_en && cnt_last) begin
          state_d  = CRC;
          cnt_load = 1'b1;
          cnt_val  = (type_q == TOKEN) ? CNT_W'(SIE_CRC5_BITS) : CNT_W'(SIE_CRC16_BITS);
        end
      end
      CRC: begin
        err_d = any_start;
        if (bit_en && cnt_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      type_q     <= TOKEN;
      pid_sr_q   <= '0;
      pay_bits_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      pid_sr_q   <= pid_sr_d;
      pay_bits_q <= pay_bits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_sie_tx_mux.sv
// Scoreboard bench for sie_tx_mux: the driver expands each accepted start
// into the expected wire bit sequence; the monitor pops it on every consume.
module tb_sie_tx_mux;

  localparam int unsigned TOKEN_BITS = 11;
  localparam int unsigned MAX_BYTES  = 64;
  localparam int unsigned LEN_W      = 7;

  logic clk = 1'b0;
  logic rst;
  logic token_pkt, data_pkt, hs_pkt, bit_en;
  logic [3:0] pid;
  logic [LEN_W-1:0] data_len;
  logic stream5, stream16, crc5, crc16;
  logic out_to_stuff, out_valid, stream_adv, crc_adv, busy, done, err;

  always #5 clk = ~clk;

  sie_tx_mux #(.TOKEN_BITS(TOKEN_BITS), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .token_pkt(token_pkt), .data_pkt(data_pkt), .hs_pkt(hs_pkt),
    .pid(pid), .data_len(data_len), .stream5(stream5), .stream16(stream16),
    .crc5(crc5), .crc16(crc16), .bit_en(bit_en), .out_to_stuff(out_to_stuff),
    .out_valid(out_valid), .stream_adv(stream_adv), .crc_adv(crc_adv),
    .busy(busy), .done(done), .err(err)
  );

  // Serial sources: random bit memories that step when the DUT strobes them.
  bit pay5 [1024];
  bit pay16[1024];
  bit cr5  [1024];
  bit cr16 [1024];
  int unsigned p_s = 0;
  int unsigned p_c = 0;
  assign stream5  = pay5 [p_s % 1024];
  assign stream16 = pay16[p_s % 1024];
  assign crc5     = cr5  [p_c % 1024];
  assign crc16    = cr16 [p_c % 1024];

  typedef struct packed { logic b; logic sa; logic ca; logic last; } item_t;
  item_t expq[$];
  int    errq[$];
  bit    m_active = 1'b0;
  int    m_act_from = 0;
  int    done_exp = -1;
  int    cyc = 0;
  int    be_mode = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares every cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit exp_act;
        bit exp_err;
        exp_act = m_active && (cyc >= m_act_from) && (expq.size() > 0);
        chk("out_valid", 32'(out_valid), 32'(exp_act));
        chk("busy", 32'(busy), 32'(exp_act));
        if (exp_act) begin
          item_t it;
          it = expq[0];
          chk("bit", 32'(out_to_stuff), 32'(it.b));
          chk("stream_adv", 32'(stream_adv), 32'(it.sa & bit_en));
          chk("crc_adv", 32'(crc_adv), 32'(it.ca & bit_en));
          if (bit_en) begin
            void'(expq.pop_front());
            if (it.last) begin
              m_active = 1'b0;
              done_exp = cyc + 1;
            end
          end
        end else begin
          chk("idle_bit", 32'(out_to_stuff), 32'd0);
          chk("idle_adv", 32'({stream_adv, crc_adv}), 32'd0);
        end
        chk("done", 32'(done), 32'(cyc == done_exp));
        while (errq.size() > 0 && errq[0] < cyc) void'(errq.pop_front());
        exp_err = (errq.size() > 0 && errq[0] == cyc);
        if (exp_err) void'(errq.pop_front());
        chk("err", 32'(err), 32'(exp_err));
        if (stream_adv) p_s++;
        if (crc_adv) p_c++;
      end
    end
  end

  // Stuffer readiness pattern.
  initial begin
    bit_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (be_mode)
        0:       bit_en = 1'b1;
        1:       bit_en = 1'($urandom % 2);
        default: bit_en = ~bit_en;
      endcase
    end
  end

  task automatic push_bit(input logic b, input logic sa, input logic ca);
    item_t it;
    it.b = b; it.sa = sa; it.ca = ca; it.last = 1'b0;
    expq.push_back(it);
  endtask

  // Issue start inputs for one cycle (called at posedge+1) and build expectations.
  task automatic issue(input bit t, input bit d, input bit h, input logic [3:0] p,
                       input logic [LEN_W-1:0] len);
    bit hs_eff;
    int nstart, npay, ncrc;
    logic [3:0] np;
`ifdef SIE_TX_MUX_HS_EN
    hs_eff = h;
`else
    hs_eff = 1'b0;
`endif
    token_pkt = t; data_pkt = d; hs_pkt = h; pid = p; data_len = len;
    nstart = int'(t) + int'(d) + int'(hs_eff);
    if (nstart > 0) begin
      if (m_active) begin
        errq.push_back(cyc + 1);
      end else begin
        if (nstart > 1 || (!t && d && len > MAX_BYTES)) errq.push_back(cyc + 1);
        np = ~p;
        for (int i = 0; i < 4; i++) push_bit(p[i], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_bit(np[i], 1'b0, 1'b0);
        if (t) begin
          npay = TOKEN_BITS; ncrc = 5;
        end else if (d) begin
          npay = ((len > MAX_BYTES) ? MAX_BYTES : int'(len)) * 8; ncrc = 16;
        end else begin
          npay = 0; ncrc = 0;
        end
        for (int i = 0; i < npay; i++)
          push_bit(t ? pay5[(p_s + i) % 1024] : pay16[(p_s + i) % 1024], 1'b1, 1'b0);
        for (int i = 0; i < ncrc; i++)
          push_bit(t ? cr5[(p_c + i) % 1024] : cr16[(p_c + i) % 1024], 1'b0, 1'b1);
        expq[expq.size() - 1].last = 1'b1;
        m_act_from = cyc + 1;
        m_active = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    token_pkt = 1'b0; data_pkt = 1'b0; hs_pkt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_active = 1'b0;
    expq.delete();
    errq.delete();
    done_exp = -1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (m_active && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("idle_timeout", 32'(m_active), 32'd0);
    if (m_active) do_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      pay5[i] = 1'($urandom); pay16[i] = 1'($urandom);
      cr5[i]  = 1'($urandom); cr16[i]  = 1'($urandom);
    end
    rst = 1'b0; token_pkt = 1'b0; data_pkt = 1'b0; hs_pkt = 1'b0;
    pid = '0; data_len = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Handshake (or ignored hs_pkt in the default build).
    issue(0, 0, 1, 4'b0010, '0);
    repeat (3) @(posedge clk);
    #1;
    wait_idle(100);
    // Token, zero-length data, clamped data.
    issue(1, 0, 0, 4'b0001, '0);
    wait_idle(100);
    issue(0, 1, 0, 4'b0011, 7'd0);
    wait_idle(100);
    issue(0, 1, 0, 4'b1011, 7'd70);
    wait_idle(1000);
    // Coincident starts, then a start while busy.
    issue(1, 1, 0, 4'b1001, 7'd2);
    wait_idle(100);
    issue(1, 0, 0, 4'b0101, '0);
    repeat (3) @(posedge clk);
    #1;
    issue(0, 1, 0, 4'b1111, 7'd1);
    wait_idle(100);
    // Alternating stuffer ready.
    be_mode = 2;
    issue(0, 1, 0, 4'b0110, 7'd3);
    wait_idle(300);
    be_mode = 0;
    // Reset during token payload bit 5, then a clean token.
    begin
      int unsigned base;
      int k;
      base = p_s;
      k = 0;
      issue(1, 0, 0, 4'b1100, '0);
      while (p_s < base + 5 && k < 100) begin
        @(posedge clk);
        #1;
        k++;
      end
      chk("reach_payload5", 32'(p_s - base), 32'd5);
      do_reset();
      @(posedge clk);
      #1;
      issue(1, 0, 0, 4'b1010, '0);
      wait_idle(100);
    end
    // Randomized traffic, including back-to-back restarts and intrusions.
    for (int n = 0; n < 40; n++) begin
      bit t, d, h;
      int sel;
      logic [LEN_W-1:0] len;
      be_mode = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 5));
      t = (sel == 0) || (sel == 4);
      d = (sel == 1) || (sel == 2) || (sel == 4);
      h = (sel == 3) || (sel == 5);
      len = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(65, 127))
                                        : LEN_W'($urandom_range(0, 10));
      issue(t, d, h, 4'($urandom), len);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
        issue(1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), LEN_W'($urandom_range(0, 4)));
      end
      wait_idle(2000);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    be_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
